// File: rtl/complex_divider_pkg.sv
// Shared widths, saturation limit and FSM encoding for the complex divider.
package complex_divider_pkg;

    localparam int IN_W   = 32;
    localparam int OUT_W  = 34;
    localparam int PROD_W = 64;
    localparam int NUM_W  = 65;

    localparam logic [OUT_W-1:0] SAT_MAX = 34'h1_FFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        PREP,
        DIV,
        OUT
    } state_t;

    // |x| of a 65-bit signed numerator; the result never exceeds 2^63.
    function automatic logic [PROD_W-1:0] magnitude(input logic signed [NUM_W-1:0] x);
        return PROD_W'(x[NUM_W-1] ? -x : x);
    endfunction

endpackage

// File: rtl/udiv_core.sv
// One restoring-division step per cycle: unsigned (64+FRAC_BITS)-bit dividend by 64-bit divisor.
module udiv_core
    import complex_divider_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic                          step,
    input  logic [PROD_W+FRAC_BITS-1:0]   dividend,
    input  logic [PROD_W-1:0]             divisor,
    output logic [PROD_W+FRAC_BITS-1:0]   quotient
);

    localparam int DW = PROD_W + FRAC_BITS;

    logic [PROD_W-1:0] rem;
    logic [DW-1:0]     work;
    logic [PROD_W:0]   trial;
    logic              fits;

    // Dividend bits leave the top of work while quotient bits enter at the bottom.
    always_comb begin
        trial = {rem, work[DW-1]};
        fits  = (trial >= {1'b0, divisor});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            work <= '0;
        end else if (load) begin
            rem  <= '0;
            work <= dividend;
        end else if (step) begin
            rem  <= fits ? PROD_W'(trial - {1'b0, divisor}) : trial[PROD_W-1:0];
            work <= {work[DW-2:0], fits};
        end
    end

    assign quotient = work;

endmodule

// File: rtl/complex_divider.sv
// Fixed-latency complex divider (a+jb)/(c+jd) with fixed-point, symmetrically saturated outputs.
module complex_divider
    import complex_divider_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic                 sys_clk_i,
    input  logic                 rst_n_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [IN_W-1:0]      num_real_i,
    input  logic [IN_W-1:0]      num_imag_i,
    input  logic [IN_W-1:0]      den_real_i,
    input  logic [IN_W-1:0]      den_imag_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [OUT_W-1:0]     data_out_real_o,
    output logic [OUT_W-1:0]     data_out_imag_o,
    output logic                 div_zero_o,
    output logic                 overflow_o
);

    localparam int DW    = PROD_W + FRAC_BITS;
    localparam int CNT_W = $clog2(DW);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DW - 1);

    state_t state, state_next;

    logic signed [IN_W-1:0]   a, b, c, d;
    logic signed [PROD_W-1:0] ac, bd, bc, ad;
    logic [PROD_W-1:0]        cc, dd;
    logic [PROD_W-1:0]        den;
    logic                     neg_re, neg_im, den_zero;
    logic [CNT_W-1:0]         cnt;

    logic signed [NUM_W-1:0]  num_re, num_im;
    logic [PROD_W-1:0]        den_sum;
    logic [DW-1:0]            dvd_re, dvd_im, q_re, q_im;
    logic                     sat_re, sat_im;
    logic [OUT_W-1:0]         mag_re, mag_im;

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid_i) state_next = MUL;
            MUL:     state_next = PREP;
            PREP:    state_next = DIV;
            DIV:     if (cnt == LAST) state_next = OUT;
            OUT:     if (ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        num_re  = NUM_W'(ac) + NUM_W'(bd);
        num_im  = NUM_W'(bc) - NUM_W'(ad);
        den_sum = cc + dd;
        dvd_re  = DW'(magnitude(num_re)) << FRAC_BITS;
        dvd_im  = DW'(magnitude(num_im)) << FRAC_BITS;
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a        <= '0;
            b        <= '0;
            c        <= '0;
            d        <= '0;
            ac       <= '0;
            bd       <= '0;
            bc       <= '0;
            ad       <= '0;
            cc       <= '0;
            dd       <= '0;
            den      <= '0;
            neg_re   <= 1'b0;
            neg_im   <= 1'b0;
            den_zero <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (valid_i) begin
                    a <= num_real_i;
                    b <= num_imag_i;
                    c <= den_real_i;
                    d <= den_imag_i;
                end
                MUL: begin
                    ac <= PROD_W'(a) * PROD_W'(c);
                    bd <= PROD_W'(b) * PROD_W'(d);
                    bc <= PROD_W'(b) * PROD_W'(c);
                    ad <= PROD_W'(a) * PROD_W'(d);
                    cc <= PROD_W'(c) * PROD_W'(c);
                    dd <= PROD_W'(d) * PROD_W'(d);
                end
                PREP: begin
                    den      <= den_sum;
                    neg_re   <= num_re[NUM_W-1];
                    neg_im   <= num_im[NUM_W-1];
                    den_zero <= (den_sum == '0);
                    cnt      <= '0;
                end
                DIV:     cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Dividends are loaded straight from the PREP-cycle sums; signs are reapplied at the output.
    udiv_core #(.FRAC_BITS(FRAC_BITS)) u_div_re (
        .clk      (sys_clk_i),
        .rst_n    (rst_n_i),
        .load     (state == PREP),
        .step     (state == DIV),
        .dividend (dvd_re),
        .divisor  (den),
        .quotient (q_re)
    );

    udiv_core #(.FRAC_BITS(FRAC_BITS)) u_div_im (
        .clk      (sys_clk_i),
        .rst_n    (rst_n_i),
        .load     (state == PREP),
        .step     (state == DIV),
        .dividend (dvd_im),
        .divisor  (den),
        .quotient (q_im)
    );

    always_comb begin
        sat_re = (q_re > DW'(SAT_MAX));
        sat_im = (q_im > DW'(SAT_MAX));
        mag_re = sat_re ? SAT_MAX : q_re[OUT_W-1:0];
        mag_im = sat_im ? SAT_MAX : q_im[OUT_W-1:0];
    end

    always_comb begin
        valid_o         = (state == OUT);
        ready_o         = (state == IDLE);
        data_out_real_o = '0;
        data_out_imag_o = '0;
        div_zero_o      = 1'b0;
        overflow_o      = 1'b0;
        if (state == OUT) begin
            if (den_zero) begin
                data_out_real_o = SAT_MAX;
                data_out_imag_o = SAT_MAX;
                div_zero_o      = 1'b1;
            end else begin
                data_out_real_o = neg_re ? -mag_re : mag_re;
                data_out_imag_o = neg_im ? -mag_im : mag_im;
                overflow_o      = sat_re | sat_im;
            end
        end
    end

endmodule

// File: tb/tb_complex_divider.sv
// Randomized scoreboard bench for complex_divider with directed corner cases.
module tb_complex_divider;

    localparam int     F      = 16;
    localparam longint SATV   = 64'd8589934591;
    // cyc is read before its own edge update, so first valid shows cyc - acc = (66+F) + 1.
    localparam int     LAT_CYC = 67 + F;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid_i = 1'b0;
    logic               ready_i = 1'b0;
    logic signed [31:0] na = '0, nb = '0, dc = '0, dd = '0;
    logic               ready_o, valid_o, div_zero_o, overflow_o;
    logic [33:0]        out_re, out_im;

    complex_divider #(.FRAC_BITS(F)) dut (
        .sys_clk_i       (clk),
        .rst_n_i         (rst_n),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .num_real_i      (na),
        .num_imag_i      (nb),
        .den_real_i      (dc),
        .den_imag_i      (dd),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .data_out_real_o (out_re),
        .data_out_imag_o (out_im),
        .div_zero_o      (div_zero_o),
        .overflow_o      (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint re;
        longint im;
        bit     dz;
        bit     ov;
        int     acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   hold_low = 1'b0;
    bit   rand_bp = 1'b0;
    bit   prev_v = 1'b0;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    // Reference: exact rational arithmetic on wide integers, truncate toward zero, clamp.
    function automatic exp_t model(input logic signed [31:0] a, b, c, d);
        exp_t e;
        logic signed [127:0] A, B, C, D, re, im, den;
        logic [127:0] qr, qi;
        logic [127:0] lim;
        lim = 128'd8589934591;
        A = a; B = b; C = c; D = d;
        re  = A * C + B * D;
        im  = B * C - A * D;
        den = C * C + D * D;
        e.acc = 0;
        e.ov  = 1'b0;
        e.dz  = (den == 0);
        if (e.dz) begin
            e.re = SATV;
            e.im = SATV;
        end else begin
            qr = (re < 0) ? -re : re;
            qi = (im < 0) ? -im : im;
            qr = (qr << F) / den;
            qi = (qi << F) / den;
            e.ov = (qr > lim) || (qi > lim);
            if (qr > lim) qr = lim;
            if (qi > lim) qi = lim;
            e.re = (re < 0) ? -longint'(qr) : longint'(qr);
            e.im = (im < 0) ? -longint'(qi) : longint'(qi);
        end
        return e;
    endfunction

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = ready_o;
        end
        if (!ok) begin
            chk("ready_timeout", 0, 1);
            summary();
            $fatal(1, "ready_o never returned");
        end
    endtask

    task automatic issue(input logic signed [31:0] a, b, c, d, input exp_t e);
        wait_ready();
        na = a; nb = b; dc = c; dd = d;
        valid_i = 1'b1;
        @(posedge clk);
        e.acc = cyc;
        sb.push_back(e);
        #1;
        valid_i = 1'b0;
        na = $urandom; nb = $urandom; dc = $urandom; dd = $urandom;
    endtask

    task automatic issue_rand(input logic signed [31:0] a, b, c, d);
        issue(a, b, c, d, model(a, b, c, d));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, ready_o, 1);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_re"}, $signed(out_re), 0);
        chk({tag, "_im"}, $signed(out_im), 0);
        chk({tag, "_dz"}, div_zero_o, 0);
        chk({tag, "_ov"}, overflow_o, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready_i = hold_low ? 1'b0 : (rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (valid_o && !prev_v) begin
                if (sb.size() == 0) chk("spurious_valid", 1, 0);
                else                chk("latency", cyc - sb[0].acc, LAT_CYC);
            end
            if (valid_o && ready_i && sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("real", $signed(out_re), mon_e.re);
                chk("imag", $signed(out_im), mon_e.im);
                chk("div_zero", div_zero_o, mon_e.dz);
                chk("overflow", overflow_o, mon_e.ov);
            end
            prev_v = valid_o;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        summary();
        $fatal(1, "watchdog");
    end

    function automatic logic signed [31:0] pick(input int mode);
        logic signed [31:0] ext [5];
        ext[0] = 32'sh8000_0000;
        ext[1] = 32'sh7FFF_FFFF;
        ext[2] = 32'sd0;
        ext[3] = 32'sd1;
        ext[4] = -32'sd1;
        case (mode)
            0:       return $urandom;
            1:       return 32'($signed($urandom_range(0, 200)) - 100);
            default: return ext[$urandom_range(0, 4)];
        endcase
    endfunction

    initial begin
        logic signed [31:0] ra, rb, rc, rd;
        bit ok;
        int mode;

        #23;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        issue(4, 2, 1, 1, '{196608, -65536, 1'b0, 1'b0, 0});
        issue(1, 0, 0, 2, '{0, -32768, 1'b0, 1'b0, 0});
        issue(5, 7, 0, 0, '{SATV, SATV, 1'b1, 1'b0, 0});
        issue(32'sh7FFF_FFFF, 0, 1, 0, '{SATV, 0, 1'b0, 1'b1, 0});
        issue(-7, 3, 2, 0, '{-229376, 98304, 1'b0, 1'b0, 0});

        // Backpressure: result held for 5 cycles while new operands are offered.
        wait_ready();
        hold_low = 1'b1;
        @(posedge clk);
        #2;
        issue(4, 2, 1, 1, '{196608, -65536, 1'b0, 1'b0, 0});
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = valid_o;
        end
        chk("bp_valid_seen", ok, 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_re", $signed(out_re), 196608);
            chk("bp_hold_im", $signed(out_im), -65536);
            chk("bp_hold_flags", {div_zero_o, overflow_o}, 0);
            chk("bp_hold_valid", valid_o, 1);
            chk("bp_hold_ready", ready_o, 0);
            na = 9; nb = -9; dc = 3; dd = 1;
            valid_i = 1'b1;
            @(negedge clk);
        end
        valid_i = 1'b0;
        hold_low = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("bp_valid_fall", valid_o, 0);
        chk("bp_ready_rise", ready_o, 1);

        // Reset mid-division, then an operation on the first edge after release.
        issue_rand(123, -456, 789, 10);
        repeat (32) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        sb.delete();
        na = 4; nb = 2; dc = 1; dd = 1;
        valid_i = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        sb.push_back('{196608, -65536, 1'b0, 1'b0, cyc});
        #1;
        valid_i = 1'b0;

        rand_bp = 1'b1;
        for (int n = 0; n < 30; n++) begin
            mode = $urandom_range(0, 3);
            ra = pick(mode == 3 ? 2 : mode);
            rb = pick(mode == 3 ? 2 : mode);
            rc = pick(mode == 3 ? 2 : mode);
            rd = pick(mode == 3 ? 2 : mode);
            if ($urandom_range(0, 9) == 0) begin
                rc = 0;
                rd = 0;
            end
            issue_rand(ra, rb, rc, rd);
        end

        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = (sb.size() == 0);
        end
        chk("scoreboard_drained", sb.size(), 0);
        summary();
        $finish;
    end

endmodule
